// File: rtl/prefetch_queue.sv
// Instruction prefetch unit: runs ahead of the PC, fetching sequential words from
// paged SDRAM into a DEPTH-entry FIFO; flushes on redirect and idles in boot mode.
module prefetch_queue #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 16,
   parameter int PAGE_W  = 8,
   parameter int INSTR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     boot_mode,
   input  logic                     pc_load,
   input  logic [ADDR_W-1:0]        pc_in,
   input  logic [PAGE_W-1:0]        page_in,
   input  logic                     deq,
   output logic [INSTR_W-1:0]       instr_out,
   output logic [ADDR_W-1:0]        instr_addr,
   output logic                     instr_valid,
   output logic                     mem_req,
   output logic [PAGE_W+ADDR_W-1:0] mem_addr,
   input  logic                     mem_busy,
   input  logic                     mem_cack,
   input  logic                     mem_ready,
   input  logic [INSTR_W-1:0]       mem_rdata,
   output logic                     fetching
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t                     state_q;
   logic                       mem_req_q;
   logic [PAGE_W+ADDR_W-1:0]   mem_addr_q;
   logic [CNT_W-1:0]           count_q, count_d;
   logic [PTR_W-1:0]           rd_ptr_q, wr_ptr_q;
   logic [ADDR_W-1:0]          fetch_addr_q, fetch_addr_d;
   logic [PAGE_W-1:0]          page_q, page_d;
   logic                       discard_q;

   logic [INSTR_W-1:0]         data_q [DEPTH];
   logic [ADDR_W-1:0]          addr_q [DEPTH];

   logic flush, has_room, start, rsp, we, pop;

   always_comb begin
      flush    = pc_load | boot_mode;
      has_room = (count_q != CNT_W'(DEPTH));
      rsp      = (state_q == WAIT) && mem_ready;
      // A response is kept only if no flush raced it or preceded it.
      we       = rsp && !discard_q && !flush;
      pop      = deq && (count_q != '0) && !flush;
      // A redirect in IDLE launches straight to the new target with an empty queue.
      start    = (state_q == IDLE) && !boot_mode && !mem_busy && (pc_load || has_room);

      fetch_addr_d = fetch_addr_q;
      page_d       = page_q;
      count_d      = count_q + CNT_W'(we) - CNT_W'(pop);
      if (flush) begin
         fetch_addr_d = pc_in;
         page_d       = page_in;
         count_d      = '0;
      end else if (we) begin
         fetch_addr_d = fetch_addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         fetch_addr_q <= '0;
         page_q       <= '0;
         discard_q    <= 1'b0;
      end else begin
         count_q      <= count_d;
         fetch_addr_q <= fetch_addr_d;
         page_q       <= page_d;

         if (flush)    rd_ptr_q <= wr_ptr_q;
         else if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (we)       wr_ptr_q <= wr_ptr_q + PTR_W'(1);

         if (rsp)                           discard_q <= 1'b0;
         else if (flush && state_q != IDLE) discard_q <= 1'b1;

         case (state_q)
            IDLE: if (start) begin
               state_q    <= REQ;
               mem_req_q  <= 1'b1;
               mem_addr_q <= {page_d, fetch_addr_d};
            end
            REQ: if (mem_cack) begin
               state_q   <= WAIT;
               mem_req_q <= 1'b0;
            end
            WAIT: if (mem_ready) state_q <= IDLE;
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (we && !rst) begin
         data_q[wr_ptr_q] <= mem_rdata;
         addr_q[wr_ptr_q] <= fetch_addr_q;
      end
   end

   assign instr_out   = data_q[rd_ptr_q];
   assign instr_addr  = addr_q[rd_ptr_q];
   assign instr_valid = (count_q != '0) && !boot_mode;
   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign fetching    = (state_q != IDLE);

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: per-cycle vector table plus a hand-written
// sequence covering deq on an empty queue with bounded waits.
module tb_prefetch_queue;
   logic        clk = 1'b0;
   logic        rst, boot_mode, pc_load, deq, mem_busy, mem_cack, mem_ready;
   logic [15:0] pc_in;
   logic [7:0]  page_in;
   logic [31:0] mem_rdata;
   logic [31:0] instr_out;
   logic [15:0] instr_addr;
   logic        instr_valid, mem_req, fetching;
   logic [23:0] mem_addr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   prefetch_queue #(.DEPTH(4), .ADDR_W(16), .PAGE_W(8), .INSTR_W(32)) dut (
      .clk(clk), .rst(rst), .boot_mode(boot_mode), .pc_load(pc_load),
      .pc_in(pc_in), .page_in(page_in), .deq(deq),
      .instr_out(instr_out), .instr_addr(instr_addr), .instr_valid(instr_valid),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_busy(mem_busy),
      .mem_cack(mem_cack), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .fetching(fetching)
   );

   // Memory content is a fixed function of the word address.
   function automatic logic [31:0] dat(input logic [15:0] a);
      return {~a, a};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, boot, pcl;
      logic [15:0] pc;
      logic [7:0]  pg;
      logic        dq, bs, ck, rd;
      logic [15:0] ra;
      logic        er;
      logic [23:0] ea;
      logic        ev;
      logic [15:0] eia;
      logic        ef;
   } vec_t;

   vec_t tbl[$];

   // inputs: rst boot pc_load pc_in page_in deq busy cack ready rdata_addr
   // expect: mem_req mem_addr instr_valid instr_addr fetching
   task automatic V(input logic r, b, p, input logic [15:0] pc, input logic [7:0] pg,
                    input logic dq, bs, ck, rd, input logic [15:0] ra,
                    input logic er, input logic [23:0] ea,
                    input logic ev, input logic [15:0] eia, input logic ef);
      vec_t t;
      t.rst = r; t.boot = b; t.pcl = p; t.pc = pc; t.pg = pg;
      t.dq = dq; t.bs = bs; t.ck = ck; t.rd = rd; t.ra = ra;
      t.er = er; t.ea = ea; t.ev = ev; t.eia = eia; t.ef = ef;
      tbl.push_back(t);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      rst = 0; boot_mode = 0; pc_load = 0; pc_in = 0; page_in = 0;
      deq = 0; mem_busy = 0; mem_cack = 0; mem_ready = 0; mem_rdata = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      drive_idle();
      rst = 1;

      // fill from 0x0010 page 2, ready two cycles after cack, stop at full
      V(1,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      0,16'h0000, 0);
      V(0,0,1,16'h0010,8'h02, 0,0,0,0,16'h0000, 1,24'h020010, 0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0010, 0,24'h0,      1,16'h0010, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h020011, 1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0011, 0,24'h0,      1,16'h0010, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h020012, 1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0012, 0,24'h0,      1,16'h0010, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h020013, 1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0013, 0,24'h0,      1,16'h0010, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      1,16'h0010, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      1,16'h0010, 0);
      // full: one deq -> one refill request, then drain in order
      V(0,0,0,16'h0000,8'h00, 1,0,0,0,16'h0000, 0,24'h0,      1,16'h0011, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h020014, 1,16'h0011, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      1,16'h0011, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0014, 0,24'h0,      1,16'h0011, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      1,16'h0011, 0);
      V(0,0,0,16'h0000,8'h00, 1,0,0,0,16'h0000, 0,24'h0,      1,16'h0012, 0);
      V(0,0,0,16'h0000,8'h00, 1,0,0,0,16'h0000, 1,24'h020015, 1,16'h0013, 1);
      V(0,0,0,16'h0000,8'h00, 1,0,1,0,16'h0000, 0,24'h0,      1,16'h0014, 1);
      V(0,0,0,16'h0000,8'h00, 1,0,0,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0015, 0,24'h0,      1,16'h0015, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h020016, 1,16'h0015, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      1,16'h0015, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      1,16'h0015, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0016, 0,24'h0,      1,16'h0015, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h020017, 1,16'h0015, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      1,16'h0015, 1);
      // deq and ready together at count 2: count holds, head advances
      V(0,0,0,16'h0000,8'h00, 1,0,0,1,16'h0017, 0,24'h0,      1,16'h0016, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h020018, 1,16'h0016, 1);

      // redirect while waiting for 0x0012, then redirect coinciding with ready
      V(1,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      0,16'h0000, 0);
      V(0,0,1,16'h0010,8'h02, 0,0,0,0,16'h0000, 1,24'h020010, 0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0010, 0,24'h0,      1,16'h0010, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h020011, 1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,1,16'h0000, 0,24'h0,      1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0011, 0,24'h0,      1,16'h0010, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h020012, 1,16'h0010, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      1,16'h0010, 1);
      V(0,0,1,16'h0100,8'h02, 0,0,0,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0012, 0,24'h0,      0,16'h0000, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h020100, 0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0100, 0,24'h0,      1,16'h0100, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h020101, 1,16'h0100, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      1,16'h0100, 1);
      V(0,0,1,16'h0200,8'h05, 0,0,0,1,16'h0101, 0,24'h0,      0,16'h0000, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h050200, 0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0200, 0,24'h0,      1,16'h0200, 0);

      // busy blocks a new request but never retracts an asserted one
      V(1,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      0,16'h0000, 0);
      for (int k = 0; k < 5; k++)
         V(0,0,0,16'h0000,8'h00, 0,1,0,0,16'h0000, 0,24'h0,   0,16'h0000, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h000000, 0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,1,0,0,16'h0000, 1,24'h000000, 0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,1,0,0,16'h0000, 1,24'h000000, 0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,1,1,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0000, 0,24'h0,      1,16'h0000, 0);
      V(0,0,0,16'h0000,8'h00, 0,1,0,0,16'h0000, 0,24'h0,      1,16'h0000, 0);

      // address wrap keeps page
      V(1,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      0,16'h0000, 0);
      V(0,0,1,16'hFFFF,8'h03, 0,0,0,0,16'h0000, 1,24'h03FFFF, 0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'hFFFF, 0,24'h0,      1,16'hFFFF, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h030000, 1,16'hFFFF, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      1,16'hFFFF, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0000, 0,24'h0,      1,16'hFFFF, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h030001, 1,16'hFFFF, 1);

      // reset during WAIT, then boot mode with and without a transaction in flight
      V(1,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      0,16'h0000, 0);
      V(0,0,1,16'h0040,8'h01, 0,0,0,0,16'h0000, 1,24'h010040, 0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(1,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      0,16'h0000, 0);
      V(0,0,0,16'h0000,8'h00, 0,1,0,1,16'h0040, 0,24'h0,      0,16'h0000, 0);
      for (int k = 0; k < 4; k++)
         V(0,1,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,   0,16'h0000, 0);
      V(0,0,1,16'h0080,8'h01, 0,0,0,0,16'h0000, 1,24'h010080, 0,16'h0000, 1);
      V(0,1,0,16'h0300,8'h04, 0,0,1,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(0,1,0,16'h0300,8'h04, 0,0,0,1,16'h0080, 0,24'h0,      0,16'h0000, 0);
      V(0,1,0,16'h0300,8'h04, 0,0,0,0,16'h0000, 0,24'h0,      0,16'h0000, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h040300, 0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,1,0,16'h0000, 0,24'h0,      0,16'h0000, 1);
      V(0,0,0,16'h0000,8'h00, 0,0,0,1,16'h0300, 0,24'h0,      1,16'h0300, 0);
      V(0,1,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,24'h0,      0,16'h0000, 0);
      V(0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,24'h000000, 0,16'h0000, 1);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rst; boot_mode = tbl[i].boot; pc_load = tbl[i].pcl;
         pc_in = tbl[i].pc; page_in = tbl[i].pg; deq = tbl[i].dq;
         mem_busy = tbl[i].bs; mem_cack = tbl[i].ck; mem_ready = tbl[i].rd;
         mem_rdata = dat(tbl[i].ra);
         cyc();
         chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(tbl[i].er));
         chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].ev));
         chk($sformatf("v%0d fetching", i), 32'(fetching), 32'(tbl[i].ef));
         if (tbl[i].er)
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].ea));
         if (tbl[i].ev) begin
            chk($sformatf("v%0d instr_addr", i), 32'(instr_addr), 32'(tbl[i].eia));
            chk($sformatf("v%0d instr_out", i), instr_out, dat(tbl[i].eia));
         end
      end

      // deq on an empty queue must not disturb the count
      begin
         int n;
         @(negedge clk); drive_idle(); rst = 1; cyc();
         @(negedge clk); rst = 0; pc_load = 1; pc_in = 16'h0500; page_in = 8'h07; cyc();
         @(negedge clk); pc_load = 0; pc_in = 0; page_in = 0;
         n = 0;
         while (!mem_req && n < 8) begin cyc(); n++; end
         chk("seq req_seen", 32'(mem_req), 32'd1);
         chk("seq req_addr", 32'(mem_addr), 32'h070500);
         @(negedge clk); mem_cack = 1; cyc();
         @(negedge clk); mem_cack = 0; deq = 1; cyc();
         chk("seq empty_deq valid", 32'(instr_valid), 32'd0);
         @(negedge clk); cyc();
         @(negedge clk); deq = 0; mem_ready = 1; mem_rdata = dat(16'h0500); cyc();
         chk("seq after_ready valid", 32'(instr_valid), 32'd1);
         chk("seq after_ready addr", 32'(instr_addr), 32'h0500);
         @(negedge clk); mem_ready = 0; deq = 1; cyc();
         chk("seq last_deq valid", 32'(instr_valid), 32'd0);
         chk("seq next_req addr", 32'(mem_addr), 32'h070501);
         @(negedge clk); drive_idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
Parametrised instruction prefetch unit: successor to the single-word fetch stage feeding the core decoder. Runs ahead of the program counter and fetches sequential 32-bit instructions from paged SDRAM into a DEPTH-entry FIFO. Handles the memory busy/cack/ready handshake and flushes on redirect (jump, interrupt vector, page change). Bypassed in boot mode, when instructions come straight from boot ROM.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
ADDR_W, 16, program address width (words)
PAGE_W, 8, program page width
INSTR_W, 32, instruction width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
boot_mode  in  1  high: unit idle, queue held empty
pc_load  in  1  redirect pulse: flush, refetch from pc_in
pc_in  in  ADDR_W  redirect target address
page_in  in  PAGE_W  program page, latched on pc_load
deq  in  1  core consumes head entry this cycle
instr_out  out  INSTR_W  head instruction
instr_addr  out  ADDR_W  address of head instruction
instr_valid  out  1  head entry valid
mem_req  out  1  fetch request (read, instruction access)
mem_addr  out  PAGE_W+ADDR_W  {page, word address} of request
mem_busy  in  1  bus owned by another master
mem_cack  in  1  request accepted (1-cycle pulse)
mem_ready  in  1  read data valid (1-cycle pulse)
mem_rdata  in  INSTR_W  read data
fetching  out  1  request or response outstanding

Behaviour:
- Reset (rst high at edge): state IDLE, mem_req=0, instr_valid=0, count=0, rd/wr pointers=0, fetch_addr=0, page=0, discard=0, fetching=0. Reset mid-transaction drops everything; a later mem_ready is ignored because state is IDLE.
- FSM: IDLE -> REQ when !boot_mode && !mem_busy && count < DEPTH. REQ -> WAIT on mem_cack. WAIT -> IDLE on mem_ready. At most one request outstanding.
- REQ: mem_req=1, mem_addr={page, fetch_addr} registered and stable until cack. Request is never retracted once asserted, even if mem_busy rises.
- On mem_ready in WAIT with discard=0: write {mem_rdata, fetch_addr} at wr_ptr, count+1, fetch_addr+1 (wraps modulo 2^ADDR_W, page unchanged). instr_valid goes high the cycle after mem_ready, so latency from ready to valid is 1 cycle.
- On mem_ready with discard=1: data dropped, discard cleared, no count change.
- Minimum redirect latency: pc_load at cycle 0 -> mem_req high at cycle 1 (bus free) -> cack -> ready at cycle k -> instr_valid at k+1.
- Queue output is the head entry from registered storage: instr_out/instr_addr at rd_ptr, instr_valid = count!=0.
- deq with count!=0: rd_ptr+1, count-1. deq with count==0 is ignored.
- deq and write in the same cycle: count unchanged, both pointers advance.
- Full queue: no new request while count==DEPTH. Since only one request is outstanding, a write never overflows.
- pc_load (highest priority):
  - count:=0, rd_ptr=wr_ptr, fetch_addr:=pc_in, page:=page_in.
  - If in REQ or WAIT: discard:=1, FSM continues, and that response is dropped.
  - mem_ready in the same cycle as pc_load: data dropped.
  - deq in the same cycle: ignored.
  - A new request starts only after the pending transaction completes.
- boot_mode high: no new request is started, instr_valid forced 0, queue flushed as for pc_load using current pc_in/page_in. An in-flight transaction completes and is discarded.
- fetching = (state != IDLE).

Test Plan:
1. Reset with pc_load pc_in=0x0010, page_in=0x02, memory returns ready 2 cycles after cack -> mem_addr=0x020010, then 0x020011.., instr_valid 1 cycle after first ready, instr_addr=0x0010; with deq=0, requests stop when 4 entries are held.
2. Queue full (4 entries), deq pulsed once -> exactly one new request for the next address; count returns to 4; entries come out in order with instr_addr incrementing.
3. pc_load pc_in=0x0100 while in WAIT for address 0x0012 -> queue empties the next cycle, the 0x0012 data is dropped, next mem_addr={page,0x0100}, first valid instr_addr=0x0100.
4. mem_busy held high for 5 cycles while idle with room -> mem_req stays 0. busy rises while in REQ -> mem_req stays high with a stable address until cack.
5. fetch_addr=0xFFFF, page 0x03 -> next request 0x030000 (address wraps, page unchanged). Simultaneous deq and mem_ready at count=2 -> count remains 2.
6. Synchronous rst asserted during WAIT, then mem_ready arrives -> no entry written, instr_valid=0, mem_req=0; boot_mode=1 -> no requests and instr_valid=0 throughout.
